// File: rtl/apb3_pkg.sv
// Shared types for the APB3 slot interconnect and its watchdog.
package apb3_pkg;

  localparam int unsigned SLOT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ABORT  = 2'd2
  } apb_state_e;

  // Master-facing handshake response
  typedef struct packed {
    logic ready;
    logic slverr;
  } apb_resp_t;

  localparam apb_resp_t RESP_IDLE = '{ready: 1'b1, slverr: 1'b0};
  localparam apb_resp_t RESP_ERR  = '{ready: 1'b1, slverr: 1'b1};

endpackage

// File: rtl/apb3_wdt_cnt.sv
// Saturating wait-cycle counter with clear/enable and a registered terminal-count flag.
module apb3_wdt_cnt #(
  parameter int unsigned CNT_W  = 9,
  parameter int unsigned TC_VAL = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tc_d = (cnt_d == CNT_W'(TC_VAL));
  end

  // tc tracks cnt so the compare never sits in the master's response path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= (CNT_W'(TC_VAL) == '0);
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/apb3_mux_wdt.sv
// APB3 one-master / NUM_SLOTS-slave interconnect with nibble decode, default
// error responder for unmapped slots and a per-transfer stall watchdog.
module apb3_mux_wdt
  import apb3_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned NUM_SLOTS       = 16,
  parameter logic [15:0] SLOT_EN         = 16'h001E,
  parameter int unsigned UPR_NIBBLE_POSN = 3,
  parameter int unsigned TIMEOUT         = 256,
  parameter int unsigned CNT_W           = 9
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic [ADDR_W-1:0]           PADDR,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [DATA_W-1:0]           PWDATA,
  output logic [DATA_W-1:0]           PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic [ADDR_W-1:0]           PADDRS,
  output logic                        PWRITES,
  output logic                        PENABLES,
  output logic [DATA_W-1:0]           PWDATAS,
  output logic [NUM_SLOTS-1:0]        PSELS,
  input  logic [NUM_SLOTS*DATA_W-1:0] PRDATAS,
  input  logic [NUM_SLOTS-1:0]        PREADYS,
  input  logic [NUM_SLOTS-1:0]        PSLVERRS,
  output logic                        to_sts,
  output logic [SLOT_W-1:0]           to_slot,
  input  logic                        to_clr
);

  localparam int unsigned TC_VAL = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          WDT_ON = (TIMEOUT != 0);

  apb_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOT_W-1:0] live_slot, dec_slot;
  logic              mapped;
  logic              slv_ready, slv_err;
  logic [DATA_W-1:0] slv_rdata;
  logic              wdt_clr, wdt_en, wdt_tc;
  logic              to_sts_q, to_sts_d;
  logic [SLOT_W-1:0] to_slot_q, to_slot_d;
  apb_resp_t         resp;

  assign PADDRS   = PADDR;
  assign PWRITES  = PWRITE;
  assign PENABLES = PENABLE;
  assign PWDATAS  = PWDATA;

  // Setup phase decodes the live address; later phases use the latched slot
  assign live_slot = PADDR[4*UPR_NIBBLE_POSN +: SLOT_W];
  assign dec_slot  = (state_q == ST_IDLE) ? live_slot : slot_q;
  assign mapped    = (32'(dec_slot) < NUM_SLOTS) && SLOT_EN[dec_slot];

  always_comb begin
    PSELS = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      PSELS[i] = PSEL && mapped && (dec_slot == SLOT_W'(i)) &&
                 (state_q != ST_ABORT) && !PRESET;
    end
  end

  // Response mux from the slot latched at setup
  always_comb begin
    slv_ready = 1'b0;
    slv_err   = 1'b0;
    slv_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        slv_ready = PREADYS[i];
        slv_err   = PSLVERRS[i];
        slv_rdata = PRDATAS[i*DATA_W +: DATA_W];
      end
    end
  end

  apb3_wdt_cnt #(
    .CNT_W  (CNT_W),
    .TC_VAL (TC_VAL)
  ) u_wdt_cnt (
    .clk   (PCLK),
    .rst   (PRESET),
    .clr_i (wdt_clr),
    .en_i  (wdt_en),
    .tc_o  (wdt_tc)
  );

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    wdt_clr   = 1'b1;
    wdt_en    = 1'b0;
    resp      = RESP_IDLE;
    PRDATA    = '0;
    to_sts_d  = to_sts_q & ~to_clr;
    to_slot_d = to_slot_q;
    unique case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ST_ACCESS;
          slot_d  = live_slot;
        end else if (PSEL && PENABLE && !PRESET) begin
          resp = RESP_ERR;
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (!mapped) begin
          resp    = RESP_ERR;
          state_d = ST_IDLE;
        end else begin
          resp.ready  = slv_ready;
          resp.slverr = slv_ready & slv_err;
          PRDATA      = slv_rdata;
          // A ready slave wins over the watchdog in the terminal cycle
          if (slv_ready) begin
            state_d = ST_IDLE;
          end else if (WDT_ON && wdt_tc) begin
            state_d = ST_ABORT;
          end else begin
            wdt_clr = 1'b0;
            wdt_en  = 1'b1;
          end
        end
      end
      ST_ABORT: begin
        resp      = RESP_ERR;
        to_sts_d  = 1'b1;
        to_slot_d = slot_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      slot_q    <= '0;
      to_sts_q  <= 1'b0;
      to_slot_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      to_sts_q  <= to_sts_d;
      to_slot_q <= to_slot_d;
    end
  end

  assign PREADY  = resp.ready;
  assign PSLVERR = resp.slverr;
  assign to_sts  = to_sts_q;
  assign to_slot = to_slot_q;

endmodule

// File: tb/tb_apb3_mux_wdt.sv
// Randomized APB3 transfers against a transaction-level model of the interconnect.
module tb_apb3_mux_wdt;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NS = 16;
  localparam int unsigned TO = 8;
  localparam logic [15:0] EN = 16'h001E;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic [AW-1:0]    PADDR;
  logic             PSEL, PENABLE, PWRITE;
  logic [DW-1:0]    PWDATA;
  logic [DW-1:0]    PRDATA;
  logic             PREADY, PSLVERR;
  logic [AW-1:0]    PADDRS;
  logic             PWRITES, PENABLES;
  logic [DW-1:0]    PWDATAS;
  logic [NS-1:0]    PSELS;
  logic [NS*DW-1:0] PRDATAS;
  logic [NS-1:0]    PREADYS, PSLVERRS;
  logic             to_sts;
  logic [3:0]       to_slot;
  logic             to_clr;

  int n_checks = 0;
  int n_errors = 0;
  bit       exp_sts  = 1'b0;
  bit [3:0] exp_slot = 4'd0;

  always #5 PCLK = ~PCLK;

  apb3_mux_wdt #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_SLOTS(NS), .SLOT_EN(EN),
    .UPR_NIBBLE_POSN(3), .TIMEOUT(TO), .CNT_W(4)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PADDRS(PADDRS), .PWRITES(PWRITES),
    .PENABLES(PENABLES), .PWDATAS(PWDATAS), .PSELS(PSELS), .PRDATAS(PRDATAS),
    .PREADYS(PREADYS), .PSLVERRS(PSLVERRS), .to_sts(to_sts), .to_slot(to_slot),
    .to_clr(to_clr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Random traffic on every slave, then the addressed slave's own behaviour
  task automatic drive_slaves(input int s, input bit rdy, input bit serr, input logic [31:0] dat);
    PREADYS  = 16'($urandom);
    PSLVERRS = 16'($urandom);
    for (int i = 0; i < NS; i++) PRDATAS[i*DW +: DW] = $urandom;
    if (s < NS) begin
      PREADYS[s]         = rdy;
      PSLVERRS[s]        = serr;
      PRDATAS[s*DW +: DW] = dat;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_sts"},  64'(to_sts),  64'(exp_sts));
    check({tag, "_slot"}, 64'(to_slot), 64'(exp_slot));
  endtask

  task automatic idle(input int n, input bit clr);
    PSEL = 1'b0;
    PENABLE = 1'b0;
    for (int k = 0; k < n; k++) begin
      drive_slaves(NS, 1'b0, 1'b0, 32'h0);
      to_clr = clr && (k == 0);
      #3;
      check("idle_psels",   64'(PSELS),   64'(0));
      check("idle_pready",  64'(PREADY),  64'(1));
      check("idle_pslverr", 64'(PSLVERR), 64'(0));
      check("idle_prdata",  64'(PRDATA),  64'(0));
      @(posedge PCLK); #1;
      if (to_clr) exp_sts = 1'b0;
      to_clr = 1'b0;
    end
    check_status("idle");
  endtask

  // One complete transfer; d = access cycles the slave keeps PREADY low
  task automatic xfer(input logic [31:0] addr, input bit wr, input int unsigned d,
                      input bit serr, input logic [31:0] dat, input bit clr_in_abort);
    int       s;
    bit       mapped, aborted;
    int       done_k;
    logic [15:0] onehot;
    logic [31:0] wd;
    s       = int'(addr[15:12]);
    mapped  = EN[s];
    aborted = mapped && (d >= TO);
    onehot  = mapped ? (16'h1 << s) : 16'h0;
    done_k  = !mapped ? 1 : (aborted ? TO + 1 : int'(d) + 1);
    wd      = $urandom;
    PADDR = addr; PWRITE = wr; PWDATA = wd; PSEL = 1'b1; PENABLE = 1'b0;
    drive_slaves(s, 1'b0, serr, dat);
    #3;
    check("setup_psels",   64'(PSELS),   64'(onehot));
    check("setup_pready",  64'(PREADY),  64'(1));
    check("setup_pslverr", 64'(PSLVERR), 64'(0));
    check("pass_addr",     64'(PADDRS),  64'(addr));
    check("pass_wdata",    64'(PWDATAS), 64'(wd));
    check("pass_write",    64'(PWRITES), 64'(wr));
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int k = 1; k <= done_k; k++) begin
      drive_slaves(s, (k - 1) >= int'(d), serr, dat);
      #3;
      check("acc_penables", 64'(PENABLES), 64'(1));
      if (!mapped) begin
        check("unm_psels",   64'(PSELS),   64'(0));
        check("unm_pready",  64'(PREADY),  64'(1));
        check("unm_pslverr", 64'(PSLVERR), 64'(1));
        check("unm_prdata",  64'(PRDATA),  64'(0));
      end else if (k < done_k) begin
        check("wait_psels",   64'(PSELS),   64'(onehot));
        check("wait_pready",  64'(PREADY),  64'(0));
        check("wait_pslverr", 64'(PSLVERR), 64'(0));
      end else if (!aborted) begin
        check("done_psels",   64'(PSELS),   64'(onehot));
        check("done_pready",  64'(PREADY),  64'(1));
        check("done_pslverr", 64'(PSLVERR), 64'(serr));
        check("done_prdata",  64'(PRDATA),  64'(dat));
      end else begin
        check("abort_psels",   64'(PSELS),   64'(0));
        check("abort_pready",  64'(PREADY),  64'(1));
        check("abort_pslverr", 64'(PSLVERR), 64'(1));
        check("abort_prdata",  64'(PRDATA),  64'(0));
        to_clr = clr_in_abort;
      end
      @(posedge PCLK); #1;
      to_clr = 1'b0;
    end
    if (aborted) begin
      exp_sts  = 1'b1;
      exp_slot = 4'(s);
    end
    check_status("xfer");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] a;
    int          s;
    int unsigned d;
    PRESET = 1'b1; to_clr = 1'b0;
    PADDR = 32'h0000_2000; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
    drive_slaves(2, 1'b1, 1'b0, 32'h1234_5678);
    #3;
    check("rst_psels",   64'(PSELS),   64'(0));
    check("rst_pready",  64'(PREADY),  64'(1));
    check("rst_pslverr", 64'(PSLVERR), 64'(0));
    check("rst_prdata",  64'(PRDATA),  64'(0));
    check_status("rst");
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    idle(2, 1'b0);

    // Basic write then read to slot 2
    xfer(32'h0000_2010, 1'b1, 0, 1'b0, 32'hCAFE_0002, 1'b0);
    xfer(32'h0000_2010, 1'b0, 0, 1'b0, 32'hCAFE_0002, 1'b0);
    // Disabled slot 7
    xfer(32'h0000_7000, 1'b0, 0, 1'b0, 32'hDEAD_0007, 1'b0);
    // Five wait states, slave error on completion
    xfer(32'h0000_3000, 1'b0, 5, 1'b1, 32'h3333_0003, 1'b0);
    // Timeout on slot 4, then clear
    xfer(32'h0000_4000, 1'b0, 1000, 1'b0, 32'h4444_0004, 1'b0);
    idle(2, 1'b1);
    // Ready arrives on the last access cycle before abort
    xfer(32'h0000_1000, 1'b0, TO - 1, 1'b0, 32'h1111_0001, 1'b0);
    // Slave ready exactly in the abort cycle is too late
    xfer(32'h0000_3004, 1'b1, TO, 1'b0, 32'h3333_0004, 1'b0);
    idle(1, 1'b1);
    // Set in abort beats a simultaneous clear
    xfer(32'h0000_2000, 1'b0, 1000, 1'b0, 32'h2222_0002, 1'b1);

    // PENABLE without setup gets the default error
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 32'h0000_1000;
    #3;
    check("nosetup_pready",  64'(PREADY),  64'(1));
    check("nosetup_pslverr", 64'(PSLVERR), 64'(1));
    @(posedge PCLK); #1;
    idle(1, 1'b0);

    // Reset while slot 2 stalls; status was left set above
    PADDR = 32'h0000_2000; PSEL = 1'b1; PENABLE = 1'b0;
    drive_slaves(2, 1'b0, 1'b0, 32'h0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    drive_slaves(2, 1'b0, 1'b0, 32'h0);
    PRESET = 1'b1;
    #1;
    exp_sts = 1'b0; exp_slot = 4'd0;
    check("midrst_psels",  64'(PSELS),  64'(0));
    check("midrst_pready", 64'(PREADY), 64'(1));
    check_status("midrst");
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    xfer(32'h0000_1008, 1'b0, 2, 1'b0, 32'h1111_1111, 1'b0);

    // Random traffic, back-to-back or with gaps
    for (int n = 0; n < 200; n++) begin
      s = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 15));
      a = $urandom;
      a[15:12] = 4'(s);
      case ($urandom_range(0, 5))
        0: d = 0;
        1: d = 1;
        2: d = $urandom_range(2, 6);
        3: d = TO - 1;
        4: d = TO;
        default: d = TO + 5;
      endcase
      xfer(a, 1'($urandom), d, 1'($urandom), $urandom, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)), 1'($urandom));
    end

    idle(1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
